capture_arbiter: RTL and testbench

Round-robin controller that shares one W-bit capture register bank between N requesters on the iCE40 fabric. Each requester presents a request and data; the block picks one winner per transaction, captures its data into the shared register, and holds it behind a valid/ready handshake until the consumer takes it or a timeout discards it. It sits between the parallel per-channel flop stages and a single downstream consumer.

---
 rtl/capture_arbiter_if.sv | 27 ++
 rtl/capture_arbiter.sv | 109 ++++++++++
 tb/tb_capture_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/capture_arbiter_if.sv
// Requester/consumer bundle for the shared capture register: per-requester
// request/data/grant plus the single valid/ready output channel.
interface capture_arbiter_if #(
  parameter int N = 2,
  parameter int W = 8
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]   req;
  logic [N*W-1:0] din;
  logic [N-1:0]   gnt;
  logic [W-1:0]   q;
  logic [SW-1:0]  q_src;
  logic           q_valid;
  logic           q_ready;
  logic           drop;

  modport master (
    output req, din, q_ready,
    input  gnt, q, q_src, q_valid, drop
  );

  modport slave (
    input  req, din, q_ready,
    output gnt, q, q_src, q_valid, drop
  );
endinterface

// File: rtl/capture_arbiter.sv
// Round-robin capture of one requester's word into a shared register, held
// behind valid/ready until taken or discarded after TIMEOUT idle cycles.
module capture_arbiter #(
  parameter int N       = 2,
  parameter int W       = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  capture_arbiter_if.slave     bus
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMAX = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  q_q, q_d;
  logic [SW-1:0] src_q, src_d;
  logic [SW-1:0] last_q, last_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic          valid_q, valid_d;
  logic          drop_q, drop_d;

  logic found;
  int   win;

  // Search starts just past the last winner so every requester gets a turn.
  always_comb begin
    found = 1'b0;
    win   = 0;
    for (int k = 1; k <= N; k++) begin
      if (!found && bus.req[(int'(last_q) + k) % N]) begin
        found = 1'b1;
        win   = (int'(last_q) + k) % N;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    src_d   = src_q;
    last_d  = last_q;
    timer_d = timer_q;
    valid_d = valid_q;
    gnt_d   = '0;
    drop_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          q_d        = bus.din[win*W +: W];
          src_d      = SW'(win);
          last_d     = SW'(win);
          valid_d    = 1'b1;
          gnt_d[win] = 1'b1;
          timer_d    = '0;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        // Acceptance is checked first so it wins over an expiring timer.
        if (bus.q_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end else if (TIMEOUT != 0) begin
          if (timer_q == TMAX) begin
            valid_d = 1'b0;
            drop_d  = 1'b1;
            state_d = IDLE;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      q_q     <= '0;
      src_q   <= '0;
      last_q  <= SW'(N - 1);
      timer_q <= '0;
      valid_q <= 1'b0;
      gnt_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      src_q   <= src_d;
      last_q  <= last_d;
      timer_q <= timer_d;
      valid_q <= valid_d;
      gnt_q   <= gnt_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.q       = q_q;
  assign bus.q_src   = src_q;
  assign bus.q_valid = valid_q;
  assign bus.gnt     = gnt_q;
  assign bus.drop    = drop_q;
endmodule

// File: tb/tb_capture_arbiter.sv
// Directed bench for capture_arbiter: a 2-requester and a 4-requester
// instance, each scenario in its own task with hand-computed expectations.
module tb_capture_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  capture_arbiter_if #(.N(2), .W(8)) bus2 ();
  capture_arbiter_if #(.N(4), .W(8)) bus4 ();

  capture_arbiter #(.N(2), .W(8), .TIMEOUT(15)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  capture_arbiter #(.N(4), .W(8), .TIMEOUT(15)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus2.req = '0; bus2.q_ready = 1'b0;
    bus4.req = '0; bus4.q_ready = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus2.req = 2'b11; bus2.din = 16'h3CA5; bus2.q_ready = 1'b0;
    tick();
    vectors++; if (bus2.q_valid !== 1'b0) begin $display("FAIL reset_valid got %b want 0", bus2.q_valid); miscompares++; end
    vectors++; if (bus2.gnt !== 2'b00) begin $display("FAIL reset_gnt got %b want 00", bus2.gnt); miscompares++; end
    vectors++; if (bus2.drop !== 1'b0) begin $display("FAIL reset_drop got %b want 0", bus2.drop); miscompares++; end
    vectors++; if (bus2.q !== 8'h00) begin $display("FAIL reset_q got %h want 00", bus2.q); miscompares++; end
    vectors++; if (bus2.q_src !== 1'b0) begin $display("FAIL reset_src got %0d want 0", bus2.q_src); miscompares++; end
    rst_n = 1'b1;
  endtask

  task automatic test_alternate();
    logic [1:0] exp_gnt [6] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
    logic [7:0] exp_q   [6] = '{8'hA5, 8'hA5, 8'h3C, 8'h3C, 8'hA5, 8'hA5};
    logic       exp_src [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       exp_v   [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    do_reset();
    bus2.req = 2'b11; bus2.din = 16'h3CA5; bus2.q_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      vectors++; if (bus2.gnt !== exp_gnt[i]) begin $display("FAIL alt_gnt[%0d] got %b want %b", i, bus2.gnt, exp_gnt[i]); miscompares++; end
      vectors++; if (bus2.q !== exp_q[i]) begin $display("FAIL alt_q[%0d] got %h want %h", i, bus2.q, exp_q[i]); miscompares++; end
      vectors++; if (bus2.q_src !== exp_src[i]) begin $display("FAIL alt_src[%0d] got %0d want %0d", i, bus2.q_src, exp_src[i]); miscompares++; end
      vectors++; if (bus2.q_valid !== exp_v[i]) begin $display("FAIL alt_valid[%0d] got %b want %b", i, bus2.q_valid, exp_v[i]); miscompares++; end
    end
    bus2.req = '0;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    bus2.req = 2'b10; bus2.din = 16'h9900; bus2.q_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      vectors++; if (bus2.gnt !== ((i % 2 == 0) ? 2'b10 : 2'b00)) begin $display("FAIL single_gnt[%0d] got %b", i, bus2.gnt); miscompares++; end
      vectors++; if (bus2.q_valid !== (i % 2 == 0)) begin $display("FAIL single_valid[%0d] got %b want %b", i, bus2.q_valid, (i % 2 == 0)); miscompares++; end
      vectors++; if (bus2.q !== 8'h99) begin $display("FAIL single_q[%0d] got %h want 99", i, bus2.q); miscompares++; end
    end
    bus2.req = '0;
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    bus2.req = 2'b01; bus2.din = 16'h0055; bus2.q_ready = 1'b0;
    tick();
    vectors++; if (bus2.q_valid !== 1'b1 || bus2.q !== 8'h55) begin $display("FAIL to_capture got v=%b q=%h want v=1 q=55", bus2.q_valid, bus2.q); miscompares++; end
    bus2.req = '0;
    for (int i = 1; i <= 14; i++) begin
      tick();
      vectors++; if (bus2.q_valid !== 1'b1 || bus2.drop !== 1'b0) begin $display("FAIL to_hold[%0d] got v=%b d=%b want v=1 d=0", i, bus2.q_valid, bus2.drop); miscompares++; end
    end
    tick();
    vectors++; if (bus2.q_valid !== 1'b0) begin $display("FAIL to_expire_valid got %b want 0", bus2.q_valid); miscompares++; end
    vectors++; if (bus2.drop !== 1'b1) begin $display("FAIL to_expire_drop got %b want 1", bus2.drop); miscompares++; end
    vectors++; if (bus2.q !== 8'h55) begin $display("FAIL to_expire_q got %h want 55", bus2.q); miscompares++; end
    tick();
    vectors++; if (bus2.drop !== 1'b0) begin $display("FAIL to_drop_pulse got %b want 0", bus2.drop); miscompares++; end
  endtask

  task automatic test_accept_at_expiry();
    do_reset();
    bus2.req = 2'b01; bus2.din = 16'h00C3; bus2.q_ready = 1'b0;
    tick();
    bus2.req = '0;
    for (int i = 1; i <= 14; i++) tick();
    vectors++; if (bus2.q_valid !== 1'b1) begin $display("FAIL acc_pre got %b want 1", bus2.q_valid); miscompares++; end
    bus2.q_ready = 1'b1;
    tick();
    vectors++; if (bus2.q_valid !== 1'b0 || bus2.drop !== 1'b0) begin $display("FAIL acc_edge got v=%b d=%b want v=0 d=0", bus2.q_valid, bus2.drop); miscompares++; end
    tick();
    vectors++; if (bus2.drop !== 1'b0) begin $display("FAIL acc_after got %b want 0", bus2.drop); miscompares++; end
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    bus2.req = 2'b10; bus2.din = 16'h7700; bus2.q_ready = 1'b0;
    tick();
    bus2.req = '0;
    tick(); tick();
    vectors++; if (bus2.q_valid !== 1'b1 || bus2.q !== 8'h77) begin $display("FAIL mid_hold got v=%b q=%h want v=1 q=77", bus2.q_valid, bus2.q); miscompares++; end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    vectors++; if (bus2.q_valid !== 1'b0 || bus2.q !== 8'h00 || bus2.gnt !== 2'b00 || bus2.drop !== 1'b0)
      begin $display("FAIL mid_reset got v=%b q=%h g=%b d=%b want 0/00/00/0", bus2.q_valid, bus2.q, bus2.gnt, bus2.drop); miscompares++; end
    bus2.req = 2'b11; bus2.din = 16'h2211; bus2.q_ready = 1'b1;
    tick();
    vectors++; if (bus2.gnt !== 2'b01 || bus2.q_src !== 1'b0 || bus2.q !== 8'h11) begin $display("FAIL mid_first got g=%b s=%0d q=%h want 01/0/11", bus2.gnt, bus2.q_src, bus2.q); miscompares++; end
    bus2.req = '0;
    tick();
  endtask

  task automatic test_n4_sparse();
    logic [3:0] exp_gnt [3] = '{4'b1000, 4'b0010, 4'b1000};
    logic [1:0] exp_src [3] = '{2'd3, 2'd1, 2'd3};
    do_reset();
    bus4.din = 32'h13121110; bus4.q_ready = 1'b1; bus4.req = 4'b0010;
    tick();
    vectors++; if (bus4.gnt !== 4'b0010) begin $display("FAIL n4_prime got %b want 0010", bus4.gnt); miscompares++; end
    tick();
    bus4.req = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (bus4.gnt !== exp_gnt[i]) begin $display("FAIL n4_gnt[%0d] got %b want %b", i, bus4.gnt, exp_gnt[i]); miscompares++; end
      vectors++; if (bus4.q_src !== exp_src[i] || bus4.q !== (8'h10 + 8'(exp_src[i]))) begin $display("FAIL n4_data[%0d] got s=%0d q=%h want s=%0d", i, bus4.q_src, bus4.q, exp_src[i]); miscompares++; end
      tick();
      vectors++; if (bus4.gnt !== 4'b0000) begin $display("FAIL n4_gap[%0d] got %b want 0000", i, bus4.gnt); miscompares++; end
    end
    bus4.req = '0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    bus2.req = '0; bus2.din = '0; bus2.q_ready = 1'b0;
    bus4.req = '0; bus4.din = '0; bus4.q_ready = 1'b0;
    #2;
    test_reset();
    test_alternate();
    test_single();
    test_timeout();
    test_accept_at_expiry();
    test_reset_mid_hold();
    test_n4_sparse();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
